// File: rtl/mandelbrot_coord_gen.sv
// Raster-scan coordinate generator for an HRES x VRES Mandelbrot frame.
// Define MANDELBROT_COORD_GEN_ABORT_EN to add the abort input.
module mandelbrot_coord_gen #(
   parameter int HRES = 800,
   parameter int VRES = 600,
   parameter int FPW  = 54,
   parameter int AW   = 11,
   parameter int LW   = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   input  logic           start,
`ifdef MANDELBROT_COORD_GEN_ABORT_EN
   input  logic           abort,
`endif
   input  logic [FPW-1:0] x0,
   input  logic [FPW-1:0] y0,
   input  logic [FPW-1:0] dx,
   input  logic [FPW-1:0] dy,
   output logic           out_vld,
   input  logic           out_rdy,
   output logic [FPW-1:0] x_man,
   output logic [FPW-1:0] y_man,
   output logic [AW-1:0]  adr_o,
   output logic [LW-1:0]  line_o,
   output logic           busy,
   output logic           line_done,
   output logic           frame_done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [AW-1:0] LAST_COL  = AW'(HRES - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(VRES - 1);

   state_t         r_state;
   state_t         w_next;
   logic [FPW-1:0] r_x0;
   logic [FPW-1:0] r_dx;
   logic [FPW-1:0] r_dy;
   logic [FPW-1:0] r_x;
   logic [FPW-1:0] r_y;
   logic [AW-1:0]  r_adr;
   logic [LW-1:0]  r_line;
   logic           r_line_done;
   logic           r_frame_done;
   logic           w_run;
   logic           w_start;
   logic           w_xfer;
   logic           w_eol;
   logic           w_eof;
   logic           w_abort;

   assign w_run   = (r_state == S_RUN);
   assign w_start = clk_en & ~w_run & start;
   assign w_xfer  = clk_en & w_run & out_rdy;
   assign w_eol   = (r_adr == LAST_COL);
   assign w_eof   = w_eol & (r_line == LAST_LINE);

`ifdef MANDELBROT_COORD_GEN_ABORT_EN
   assign w_abort = clk_en & w_run & abort;
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_next = S_RUN;
         S_RUN:  if (w_abort || (w_xfer && w_eof)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // x restarts from the captured origin each line; y only steps at line wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x0         <= '0;
         r_dx         <= '0;
         r_dy         <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_adr        <= '0;
         r_line       <= '0;
         r_line_done  <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (clk_en) begin
         r_line_done  <= w_xfer & w_eol;
         r_frame_done <= w_xfer & w_eof & ~w_abort;
         if (w_start) begin
            r_x0   <= x0;
            r_dx   <= dx;
            r_dy   <= dy;
            r_x    <= x0;
            r_y    <= y0;
            r_adr  <= '0;
            r_line <= '0;
         end else if (w_xfer) begin
            if (w_eol) begin
               r_adr  <= '0;
               r_x    <= r_x0;
               r_line <= r_line + 1'b1;
               r_y    <= r_y + r_dy;
            end else begin
               r_adr  <= r_adr + 1'b1;
               r_x    <= r_x + r_dx;
            end
         end
      end
   end

   assign out_vld    = w_run;
   assign busy       = w_run;
   assign x_man      = r_x;
   assign y_man      = r_y;
   assign adr_o      = r_adr;
   assign line_o     = r_line;
   assign line_done  = r_line_done;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Bench for mandelbrot_coord_gen: 4x3 frames against a raster model.
`timescale 1ns/1ps
module tb_mandelbrot_coord_gen;

   localparam int HRES = 4;
   localparam int VRES = 3;
   localparam int FPW  = 54;
   localparam int AW   = 11;
   localparam int LW   = 10;
   localparam int NPIX = HRES * VRES;

   localparam logic [FPW-1:0] ONE = 54'd1 << 49;
   localparam logic [FPW-1:0] XM2 = -(ONE << 1);
   localparam logic [FPW-1:0] YM1 = -ONE;
   localparam logic [FPW-1:0] DXH = ONE >> 1;
   localparam logic [FPW-1:0] DYQ = ONE >> 2;
   localparam logic [FPW-1:0] XP1 = ONE;

   typedef logic [2*FPW+AW+LW:0] tup_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           clk_en;
   logic           start;
   logic [FPW-1:0] x0, y0, dx, dy;
   logic           out_vld;
   logic           out_rdy;
   logic [FPW-1:0] x_man, y_man;
   logic [AW-1:0]  adr_o;
   logic [LW-1:0]  line_o;
   logic           busy, line_done, frame_done;
`ifdef MANDELBROT_COORD_GEN_ABORT_EN
   logic           abort;
`endif

   int errors = 0;
   int checks = 0;
   logic [FPW-1:0] m_x0, m_y0, m_dx, m_dy;
   tup_t obs;

   assign obs = {x_man, y_man, adr_o, line_o, out_vld};

   mandelbrot_coord_gen #(
      .HRES(HRES), .VRES(VRES), .FPW(FPW), .AW(AW), .LW(LW)
   ) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .start(start),
`ifdef MANDELBROT_COORD_GEN_ABORT_EN
      .abort(abort),
`endif
      .x0(x0), .y0(y0), .dx(dx), .dy(dy),
      .out_vld(out_vld), .out_rdy(out_rdy),
      .x_man(x_man), .y_man(y_man), .adr_o(adr_o), .line_o(line_o),
      .busy(busy), .line_done(line_done), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Pixel k of the frame is column k%HRES of line k/HRES.
   function automatic tup_t exp_tup(input int k);
      logic [FPW-1:0] c, l;
      c = FPW'(k % HRES);
      l = FPW'(k / HRES);
      return {m_x0 + c * m_dx, m_y0 + l * m_dy,
              AW'(k % HRES), LW'(k / HRES), 1'b1};
   endfunction

   function automatic logic [FPW-1:0] rnd();
      return FPW'({$urandom(), $urandom()});
   endfunction

   task automatic start_frame(input logic [FPW-1:0] ax0, ay0, adx, ady);
      m_x0 = ax0; m_y0 = ay0; m_dx = adx; m_dy = ady;
      x0 = ax0; y0 = ay0; dx = adx; dy = ady;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clk_en = 1'b1; start = 1'b0; out_rdy = 1'b0;
      x0 = '0; y0 = '0; dx = '0; dy = '0;
`ifdef MANDELBROT_COORD_GEN_ABORT_EN
      abort = 1'b0;
`endif
      #3;
      checks++;
      if ({obs, busy, line_done, frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_async got %h/%b%b%b exp 0", obs, busy, line_done, frame_done);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({obs, busy, line_done, frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_idle got %h/%b%b%b exp 0", obs, busy, line_done, frame_done);
      end
   endtask

   task automatic test_frame(input int pct, input logic [FPW-1:0] ax0, ay0, adx, ady);
      int k, cyc;
      logic eld, efd;
      start_frame(ax0, ay0, adx, ady);
      k = 0; cyc = 0; eld = 1'b0; efd = 1'b0;
      while (k < NPIX && cyc < 300) begin
         checks++;
         if (obs !== exp_tup(k) || busy !== 1'b1 || line_done !== eld || frame_done !== efd) begin
            errors++;
            $display("FAIL frame pct=%0d k=%0d got %h/%b%b%b exp %h/1%b%b",
                     pct, k, obs, busy, line_done, frame_done, exp_tup(k), eld, efd);
         end
         out_rdy = ($urandom_range(99) < pct);
         eld = out_rdy && (k % HRES == HRES - 1);
         efd = out_rdy && (k == NPIX - 1);
         if (out_rdy) k++;
         cyc++;
         @(negedge clk);
      end
      checks++;
      if (k != NPIX) begin
         errors++;
         $display("FAIL frame_timeout pct=%0d got %0d transfers exp %0d", pct, k, NPIX);
      end
      checks++;
      if (pct >= 100 && cyc != NPIX) begin
         errors++;
         $display("FAIL throughput got %0d cycles exp %0d", cyc, NPIX);
      end
      checks++;
      if ({out_vld, busy, line_done, frame_done} !== {2'b00, eld, efd}) begin
         errors++;
         $display("FAIL frame_end got %b%b%b%b exp 00%b%b", out_vld, busy, line_done, frame_done, eld, efd);
      end
      out_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_vld, line_done, frame_done} !== 3'b000) begin
         errors++;
         $display("FAIL frame_after got %b%b%b exp 000", out_vld, line_done, frame_done);
      end
   endtask

   task automatic test_start_in_run();
      int k, cyc;
      logic eld, efd;
      start_frame(XM2, YM1, DXH, DYQ);
      k = 0; cyc = 0; eld = 1'b0; efd = 1'b0;
      while (k < NPIX && cyc < 300) begin
         checks++;
         if (obs !== exp_tup(k) || line_done !== eld || frame_done !== efd) begin
            errors++;
            $display("FAIL start_in_run k=%0d got %h/%b%b exp %h/%b%b",
                     k, obs, line_done, frame_done, exp_tup(k), eld, efd);
         end
         start = (k == 2);
         if (k == 2) x0 = XP1;
         out_rdy = ($urandom_range(1) == 1);
         eld = out_rdy && (k % HRES == HRES - 1);
         efd = out_rdy && (k == NPIX - 1);
         if (out_rdy) k++;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      out_rdy = 1'b0;
      checks++;
      if ({k == NPIX, out_vld, frame_done} !== 3'b101) begin
         errors++;
         $display("FAIL start_in_run_end got k=%0d vld=%b fd=%b exp k=%0d vld=0 fd=1",
                  k, out_vld, frame_done, NPIX);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      start_frame(rnd(), rnd(), rnd(), rnd());
      out_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (obs !== exp_tup(k)) begin
            errors++;
            $display("FAIL reset_mid_pre k=%0d got %h exp %h", k, obs, exp_tup(k));
         end
         @(negedge clk);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({obs, busy, line_done, frame_done} !== '0) begin
         errors++;
         $display("FAIL reset_mid_async got %h/%b%b%b exp 0", obs, busy, line_done, frame_done);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({out_vld, line_done, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_hold got %b%b%b exp 000", out_vld, line_done, frame_done);
         end
      end
      rst = 1'b0;
      out_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_vld, line_done, frame_done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_idle got %b%b%b exp 000", out_vld, line_done, frame_done);
      end
      test_frame(100, XM2, YM1, DXH, DYQ);
   endtask

   task automatic test_back_to_back();
      int k;
      start_frame(XM2, YM1, DXH, DYQ);
      start = 1'b1;
      out_rdy = 1'b1;
      for (k = 0; k < NPIX; k++) begin
         checks++;
         if (obs !== exp_tup(k)) begin
            errors++;
            $display("FAIL b2b_first k=%0d got %h exp %h", k, obs, exp_tup(k));
         end
         if (k == 6) x0 = XP1;
         @(negedge clk);
      end
      checks++;
      if ({out_vld, frame_done} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_gap got vld=%b fd=%b exp vld=0 fd=1", out_vld, frame_done);
      end
      @(negedge clk);
      start = 1'b0;
      m_x0 = XP1;
      for (k = 0; k < NPIX; k++) begin
         checks++;
         if (obs !== exp_tup(k)) begin
            errors++;
            $display("FAIL b2b_second k=%0d got %h exp %h", k, obs, exp_tup(k));
         end
         @(negedge clk);
      end
      out_rdy = 1'b0;
      checks++;
      if ({out_vld, frame_done} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_end got vld=%b fd=%b exp vld=0 fd=1", out_vld, frame_done);
      end
      @(negedge clk);
   endtask

   task automatic test_clk_en();
      int k, hold, cyc;
      logic eld, efd;
      start_frame(rnd(), rnd(), rnd(), rnd());
      out_rdy = 1'b1;
      k = 0; hold = 0; cyc = 0; eld = 1'b0; efd = 1'b0;
      while (k < NPIX && cyc < 300) begin
         checks++;
         if (obs !== exp_tup(k) || busy !== 1'b1 || line_done !== eld || frame_done !== efd) begin
            errors++;
            $display("FAIL clk_en k=%0d hold=%0d got %h/%b%b exp %h/%b%b",
                     k, hold, obs, line_done, frame_done, exp_tup(k), eld, efd);
         end
         if (k == 5 && hold < 3) begin
            clk_en = 1'b0;
            hold++;
            eld = 1'b0;
            efd = 1'b0;
         end else begin
            clk_en = 1'b1;
            eld = (k % HRES == HRES - 1);
            efd = (k == NPIX - 1);
            k++;
         end
         cyc++;
         @(negedge clk);
      end
      clk_en = 1'b1;
      out_rdy = 1'b0;
      checks++;
      if ({hold == 3, out_vld, frame_done} !== 3'b101) begin
         errors++;
         $display("FAIL clk_en_end got hold=%0d vld=%b fd=%b exp hold=3 vld=0 fd=1",
                  hold, out_vld, frame_done);
      end
      @(negedge clk);
   endtask

`ifdef MANDELBROT_COORD_GEN_ABORT_EN
   task automatic test_abort();
      int k;
      tup_t held;
      start_frame(XM2, YM1, DXH, DYQ);
      out_rdy = 1'b1;
      for (k = 0; k < 6; k++) begin
         checks++;
         if (obs !== exp_tup(k)) begin
            errors++;
            $display("FAIL abort_pre k=%0d got %h exp %h", k, obs, exp_tup(k));
         end
         abort = (k == 5);
         @(negedge clk);
      end
      abort = 1'b0;
      out_rdy = 1'b0;
      checks++;
      if ({out_vld, busy, line_done, frame_done} !== 4'b0000) begin
         errors++;
         $display("FAIL abort_stop got %b%b%b%b exp 0000", out_vld, busy, line_done, frame_done);
      end
      held = obs;
      abort = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== held || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got %h/%b exp %h/0", obs, frame_done, held);
         end
      end
      abort = 1'b0;
      test_frame(100, XM2, YM1, DXH, DYQ);
   endtask
`endif

   initial begin
      test_reset();
      test_frame(100, XM2, YM1, DXH, DYQ);
      test_frame(50, XM2, YM1, DXH, DYQ);
      test_frame(50, rnd(), rnd(), rnd(), rnd());
      test_start_in_run();
      test_reset_mid();
      test_back_to_back();
      test_clk_en();
`ifdef MANDELBROT_COORD_GEN_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
